// File: rtl/y86_writeback_regfile.sv
// Y86-64 write-back stage: commits E/M results to the 15-entry register file,
// serves decode reads with same-cycle write-through, and tracks RUN/STOPPED status.
module y86_writeback_regfile #(
  parameter int          CNT_W    = 64,
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_valid,
  input  logic [2:0]       W_stat,
  input  logic [3:0]       W_dstE,
  input  logic [63:0]      W_valE,
  input  logic [3:0]       W_dstM,
  input  logic [63:0]      W_valM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  output logic [2:0]       proc_stat,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic {S_RUN, S_STOPPED} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [63:0]      r_regs [0:14];
  logic [2:0]       r_proc_stat;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             w_commit;
  logic             w_fault;
  logic [2:0]       w_stat_mapped;
  logic [3:0]       w_src  [2];
  logic [63:0]      w_rval [2];

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_commit      = 1'b0;
    w_fault       = 1'b0;
    w_state_nxt   = r_state;
    w_stat_mapped = STAT_INS;
    if (W_stat == 3'd2 || W_stat == 3'd3 || W_stat == 3'd4) w_stat_mapped = W_stat;
    if (r_state == S_RUN && w_valid) begin
      if (W_stat == STAT_AOK) begin
        w_commit = 1'b1;
      end else begin
        w_fault     = 1'b1;
        w_state_nxt = S_STOPPED;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_proc_stat  <= STAT_AOK;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fault) r_proc_stat <= w_stat_mapped;
      if (w_commit && r_retire_cnt != {CNT_W{1'b1}}) r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  // NOTE: the register array is reset explicitly because the architecture defines its power-on contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= (i == 4) ? RSP_INIT : 64'h0;
    end else begin
      // M-path takes priority when both ports target the same register (popq %rsp).
      for (int i = 0; i < 15; i++) begin
        if (w_commit && W_dstM == 4'(i))      r_regs[i] <= W_valM;
        else if (w_commit && W_dstE == 4'(i)) r_regs[i] <= W_valE;
      end
    end
  end

  assign w_src[0] = d_srcA;
  assign w_src[1] = d_srcB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rval[p] = 64'h0;
      if (w_src[p] != REG_NONE) begin
        if (w_commit && W_dstM == w_src[p])      w_rval[p] = W_valM;
        else if (w_commit && W_dstE == w_src[p]) w_rval[p] = W_valE;
        else                                     w_rval[p] = r_regs[w_src[p]];
      end
    end
  end

  assign d_rvalA    = w_rval[0];
  assign d_rvalB    = w_rval[1];
  assign proc_stat  = r_proc_stat;
  assign halted     = (r_state == S_STOPPED);
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Directed bench for y86_writeback_regfile: reset values, commit and bypass,
// bubbles, halt/fault handling, mid-cycle reset and reset-aborted writes.
module tb_y86_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic        w_valid;
  logic [2:0]  W_stat;
  logic [3:0]  W_dstE;
  logic [63:0] W_valE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [2:0]  proc_stat;
  logic        halted;
  logic [63:0] retire_cnt;

  int n_checks = 0;
  int n_errors = 0;

  y86_writeback_regfile #(.CNT_W(64), .RSP_INIT(64'h100)) dut (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .W_stat(W_stat),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .proc_stat(proc_stat), .halted(halted), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] st, input logic [3:0] de,
                       input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    w_valid = v; W_stat = st; W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
  endtask

  task automatic idle();
    drive(1'b0, 3'd1, 4'hF, 64'h0, 4'hF, 64'h0);
  endtask

  // One rising edge, then return in the low phase for driving and sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    d_srcA = 4'hF;
    d_srcB = 4'hF;
    #12;
    for (int r = 0; r < 15; r++) begin
      d_srcA = 4'(r);
      #1;
      check($sformatf("reset_reg%0d", r), d_rvalA, (r == 4) ? 64'h100 : 64'h0);
    end
    d_srcA = 4'hF;
    #1;
    check("reset_srcF", d_rvalA, 64'h0);
    check("reset_stat", {61'h0, proc_stat}, 64'h1);
    check("reset_halted", {63'h0, halted}, 64'h0);
    check("reset_cnt", retire_cnt, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // E-path commit with same-cycle bypass
    drive(1'b1, 3'd1, 4'd3, 64'hDEAD, 4'hF, 64'h0);
    d_srcA = 4'd3;
    d_srcB = 4'd4;
    #1;
    check("bypassE_A", d_rvalA, 64'hDEAD);
    check("nobypass_B", d_rvalB, 64'h100);
    step();
    idle();
    #1;
    check("array_reg3", d_rvalA, 64'hDEAD);
    check("cnt_1", retire_cnt, 64'h1);

    // Both ports on %rsp: M-path wins
    drive(1'b1, 3'd1, 4'd4, 64'h108, 4'd4, 64'h55);
    d_srcA = 4'd4;
    #1;
    check("bypassM_prio", d_rvalA, 64'h55);
    step();
    idle();
    #1;
    check("array_reg4", d_rvalA, 64'h55);
    check("cnt_2", retire_cnt, 64'h2);

    // Distinct E and M destinations both written
    drive(1'b1, 3'd1, 4'd5, 64'hA5, 4'd6, 64'hB6);
    d_srcA = 4'd5;
    d_srcB = 4'd6;
    #1;
    check("bypass_E5", d_rvalA, 64'hA5);
    check("bypass_M6", d_rvalB, 64'hB6);
    step();
    idle();
    #1;
    check("array_reg5", d_rvalA, 64'hA5);
    check("array_reg6", d_rvalB, 64'hB6);
    check("cnt_3", retire_cnt, 64'h3);

    // Bubble: no bypass, no write, no count
    drive(1'b0, 3'd1, 4'd2, 64'h7, 4'hF, 64'h0);
    d_srcA = 4'd2;
    #1;
    check("bubble_nobypass", d_rvalA, 64'h0);
    step();
    #1;
    check("bubble_reg2", d_rvalA, 64'h0);
    check("bubble_cnt", retire_cnt, 64'h3);

    // Both dst = F: counted retire with no register change
    drive(1'b1, 3'd1, 4'hF, 64'h11, 4'hF, 64'h22);
    d_srcA = 4'hF;
    #1;
    check("dstF_read", d_rvalA, 64'h0);
    step();
    idle();
    #1;
    check("dstF_cnt", retire_cnt, 64'h4);

    // HLT: no write, status latched, then frozen
    drive(1'b1, 3'd2, 4'd1, 64'h9, 4'hF, 64'h0);
    d_srcA = 4'd1;
    #1;
    check("hlt_nobypass", d_rvalA, 64'h0);
    step();
    #1;
    check("hlt_reg1", d_rvalA, 64'h0);
    check("hlt_stat", {61'h0, proc_stat}, 64'h2);
    check("hlt_halted", {63'h0, halted}, 64'h1);
    check("hlt_cnt", retire_cnt, 64'h4);
    drive(1'b1, 3'd1, 4'd1, 64'h77, 4'hF, 64'h0);
    #1;
    check("stopped_nobypass", d_rvalA, 64'h0);
    step();
    drive(1'b1, 3'd3, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    idle();
    #1;
    check("stopped_reg1", d_rvalA, 64'h0);
    check("stopped_cnt", retire_cnt, 64'h4);
    check("stopped_stat", {61'h0, proc_stat}, 64'h2);

    // Reset pulse between edges takes effect immediately
    #1;
    rst_n = 1'b0;
    d_srcA = 4'd3;
    d_srcB = 4'd4;
    #1;
    check("midrst_reg3", d_rvalA, 64'h0);
    check("midrst_reg4", d_rvalB, 64'h100);
    check("midrst_stat", {61'h0, proc_stat}, 64'h1);
    check("midrst_halted", {63'h0, halted}, 64'h0);
    check("midrst_cnt", retire_cnt, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Commit after reset writes normally
    drive(1'b1, 3'd1, 4'd2, 64'h42, 4'hF, 64'h0);
    d_srcA = 4'd2;
    step();
    idle();
    #1;
    check("postrst_reg2", d_rvalA, 64'h42);
    check("postrst_cnt", retire_cnt, 64'h1);

    // Undefined status code 6 maps to INS
    drive(1'b1, 3'd6, 4'd2, 64'h99, 4'hF, 64'h0);
    step();
    idle();
    #1;
    check("stat6_proc", {61'h0, proc_stat}, 64'h4);
    check("stat6_halted", {63'h0, halted}, 64'h1);
    check("stat6_reg2", d_rvalA, 64'h42);

    // Reset held across an edge aborts the pending commit
    rst_n = 1'b0;
    drive(1'b1, 3'd1, 4'd7, 64'h99, 4'hF, 64'h0);
    d_srcA = 4'd7;
    step();
    idle();
    rst_n = 1'b1;
    #1;
    check("abort_reg7", d_rvalA, 64'h0);
    check("abort_cnt", retire_cnt, 64'h0);
    check("abort_halted", {63'h0, halted}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/y86_writeback_regfile.md
Name: y86_writeback_regfile

Overview:
Write-back end of the Y86-64 pipeline: consumes the E-path result (dstE/valE) and the M-path result (dstM/valM) retiring from the W register. Commits them to the 15-entry program register file and serves the decode-stage read ports. Tracks processor status with a RUN/STOPPED state machine and counts retired instructions. Sits between the W pipeline register and decode; it is the consumer of the execute stage's e_dstE / valE path.

Parameters:
CNT_W, 64, width of retired-instruction counter
RSP_INIT, 64'h0, reset value of register 4 (%rsp)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
w_valid  input  1  W stage holds a real instruction (0 = bubble)
W_stat  input  3  status of retiring instr: 1=AOK, 2=HLT, 3=ADR, 4=INS
W_dstE  input  4  E-path destination register, 4'hF = none
W_valE  input  64  E-path write data
W_dstM  input  4  M-path destination register, 4'hF = none
W_valM  input  64  M-path write data
d_srcA  input  4  decode read port A address, 4'hF = none
d_srcB  input  4  decode read port B address, 4'hF = none
d_rvalA  output  64  read data A
d_rvalB  output  64  read data B
proc_stat  output  3  architectural status
halted  output  1  1 while in STOPPED
retire_cnt  output  CNT_W  number of committed AOK instructions

Behaviour:
- Reset (async, rst_n=0): regs 0-14 <= 0 except reg 4 <= RSP_INIT; proc_stat <= 1 (AOK); halted <= 0; retire_cnt <= 0; state <= RUN. Reset asserted mid-operation aborts any pending write; no partial commit.
- State RUN:
  - commit = w_valid & W_stat==1.
  - On commit: if W_dstE != F, write W_valE to reg[W_dstE]. If W_dstM != F, write W_valM to reg[W_dstM]. Same register on both ports -> M-path value wins (popq %rsp semantics). retire_cnt += 1, saturating at all-ones.
  - w_valid=0: no writes, no count, state unchanged.
  - w_valid & W_stat != 1: no register writes, no count; proc_stat <= W_stat, with codes 0,5,6,7 mapped to 4 (INS); halted <= 1; go to STOPPED.
- State STOPPED: all inputs except reset ignored; registers, proc_stat, and retire_cnt frozen; only exit is reset.
- Write latency: data committed at edge N is visible in the array from edge N onward.
- Reads are combinational, zero latency:
  - address F -> 0.
  - Otherwise write-through bypass on a same-cycle commit: match W_dstM -> W_valM (priority); else match W_dstE -> W_valE; else array contents.
  - Bypass applies only when commit=1 in RUN. No bypass in STOPPED or for a bubble.
- Register 15 is never written; both dst=F -> counted retire with no register change.

Test Plan:
- Reset with RSP_INIT=64'h100 -> all d_rval reads 0 except srcA=4 reads 64'h100; proc_stat=1, halted=0, retire_cnt=0.
- Commit dstE=3, valE=64'hDEAD with srcA=3 same cycle -> d_rvalA=64'hDEAD combinationally; next cycle array holds 64'hDEAD; retire_cnt=1.
- dstE=4 valE=64'h108 and dstM=4 valM=64'h55 together -> reg4=64'h55, same-cycle bypass also 64'h55.
- w_valid=0 with dstE=2 valE=64'h7 -> reg2 unchanged, retire_cnt unchanged.
- W_stat=2 (HLT) with dstE=1 valE=64'h9 -> reg1 not written, proc_stat=2, halted=1; later AOK commits ignored. W_stat=6 from reset -> proc_stat=4.
- rst_n pulsed low mid-stream between clock edges -> immediate reset values, halted=0; the following commit writes normally.
